door_ctrl: RTL and testbench

//   Elevator car-door sequencer; the requesting side of the door-hold timer.

---
 rtl/door_ctrl.sv | 137 +++++++++++++
 tb/tb_door_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/door_ctrl.sv
// door_ctrl: elevator car-door sequencer.
//   Drives the door motor open and closed, holds the door open by running an
//   external hold timer (delay_enable / delay_done), reopens on an obstruction
//   or the open button, switches to nudge mode after repeated reopens, and
//   latches a fault on a motion timeout or on contradictory limit switches.
//   The car may move only while door_closed=1.
// Ports:
//   clk_50M       in   system clock
//   rst_n         in   synchronous active-low reset
//   arrive        in   1-cycle pulse, car stopped level at a floor
//   car_stopped   in   car stationary (gates open_btn while CLOSED)
//   open_btn      in   door-open button (synchronised level)
//   close_btn     in   door-close button (synchronised level)
//   obstruct      in   light-curtain obstruction (synchronised level)
//   open_limit    in   door fully-open limit switch
//   close_limit   in   door fully-closed limit switch
//   delay_done    in   hold timer expired
//   delay_enable  out  run hold timer (low resets it)
//   motor_open    out  drive door open
//   motor_close   out  drive door closed
//   door_closed   out  door closed and locked
//   nudge         out  slow close + buzzer, obstruction ignored
//   fault         out  latched door fault
module door_ctrl #(
  parameter int MOVE_TIMEOUT = 100_000_000,
  parameter int CNT_W        = 28,
  parameter int MAX_REOPEN   = 3
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic arrive,
  input  logic car_stopped,
  input  logic open_btn,
  input  logic close_btn,
  input  logic obstruct,
  input  logic open_limit,
  input  logic close_limit,
  input  logic delay_done,
  output logic delay_enable,
  output logic motor_open,
  output logic motor_close,
  output logic door_closed,
  output logic nudge,
  output logic fault
);

  localparam int RW = $clog2(MAX_REOPEN + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MOVE_TIMEOUT - 1);
  localparam logic [RW-1:0]    REOPEN_MAX   = RW'(MAX_REOPEN);

  typedef enum logic [2:0] {
    CLOSED, OPENING, HOLD_RST, HOLD, CLOSING, FAULT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] move_cnt, move_cnt_nxt;
  logic [RW-1:0]    reopen_cnt, reopen_cnt_nxt;
  logic             timed_out, reopen_sat, moving, nudge_nxt;

  always_comb begin
    state_nxt      = state;
    reopen_cnt_nxt = reopen_cnt;
    timed_out      = (move_cnt == TIMEOUT_LAST);
    reopen_sat     = (reopen_cnt == REOPEN_MAX);
    moving         = (state == OPENING) || (state == CLOSING);

    // Both limits at once means a broken switch: trust nothing, stop.
    if (state != FAULT && open_limit && close_limit) begin
      state_nxt = FAULT;
    end else begin
      unique case (state)
        CLOSED:   if (arrive || (open_btn && car_stopped)) state_nxt = OPENING;
        OPENING: begin
          if (open_limit)     state_nxt = HOLD_RST;
          else if (timed_out) state_nxt = FAULT;
        end
        // One cycle with enable low so the timer restarts and drops a stale done.
        HOLD_RST: state_nxt = HOLD;
        HOLD: begin
          if (open_btn || obstruct)      state_nxt = HOLD_RST;
          else if (close_btn)            state_nxt = CLOSING;
          else if (delay_done)           state_nxt = CLOSING;
        end
        CLOSING: begin
          if (close_limit) begin
            state_nxt      = CLOSED;
            reopen_cnt_nxt = '0;
          end else if (timed_out) begin
            state_nxt = FAULT;
          end else if (open_btn) begin
            state_nxt = OPENING;
          end else if (obstruct && !reopen_sat) begin
            // Once saturated we are in nudge mode and the curtain is ignored.
            state_nxt      = OPENING;
            reopen_cnt_nxt = reopen_cnt + RW'(1);
          end
        end
        FAULT:    state_nxt = FAULT;
        default:  state_nxt = FAULT;
      endcase
    end

    if (state_nxt != state) move_cnt_nxt = '0;
    else if (moving)        move_cnt_nxt = move_cnt + CNT_W'(1);
    else                    move_cnt_nxt = move_cnt;

    nudge_nxt = (reopen_cnt_nxt == REOPEN_MAX) &&
                (state_nxt == HOLD_RST || state_nxt == HOLD || state_nxt == CLOSING);
  end

  // Outputs are registered from the next state so they change on the same
  // edge that samples their cause.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state        <= CLOSED;
      move_cnt     <= '0;
      reopen_cnt   <= '0;
      delay_enable <= 1'b0;
      motor_open   <= 1'b0;
      motor_close  <= 1'b0;
      door_closed  <= 1'b1;
      nudge        <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_nxt;
      move_cnt     <= move_cnt_nxt;
      reopen_cnt   <= reopen_cnt_nxt;
      delay_enable <= (state_nxt == HOLD);
      motor_open   <= (state_nxt == OPENING);
      motor_close  <= (state_nxt == CLOSING);
      door_closed  <= (state_nxt == CLOSED);
      nudge        <= nudge_nxt;
      fault        <= (state_nxt == FAULT);
    end
  end

endmodule

// File: tb/tb_door_ctrl.sv
// Bench for door_ctrl: directed door scenarios followed by random stimulus.
// Each cycle the stimulus side advances a reference model of the door and
// queues the expected output set; a monitor pops one entry after every edge
// and compares it with the DUT. The hold timer is emulated by the bench.
module tb_door_ctrl;
  localparam int T    = 16;
  localparam int MAXR = 3;
  localparam int P_CLOSED = 0, P_OPENING = 1, P_HOLD_RST = 2,
                 P_HOLD = 3, P_CLOSING = 4, P_FAULT = 5;

  logic clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  logic rst_n = 1'b0, arrive = 1'b0, car_stopped = 1'b1, open_btn = 1'b0;
  logic close_btn = 1'b0, obstruct = 1'b0, open_limit = 1'b0, close_limit = 1'b0;
  logic delay_done = 1'b0;
  logic delay_enable, motor_open, motor_close, door_closed, nudge, fault;

  door_ctrl #(.MOVE_TIMEOUT(T), .CNT_W(8), .MAX_REOPEN(MAXR)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .arrive(arrive), .car_stopped(car_stopped),
    .open_btn(open_btn), .close_btn(close_btn), .obstruct(obstruct),
    .open_limit(open_limit), .close_limit(close_limit), .delay_done(delay_done),
    .delay_enable(delay_enable), .motor_open(motor_open), .motor_close(motor_close),
    .door_closed(door_closed), .nudge(nudge), .fault(fault)
  );

  // Reference model: door phase, edges spent in the phase, reopen count,
  // and an emulated hold timer (done 4 cycles after enable rises).
  int   ph = P_CLOSED, age = 0, reopens = 0, tmr = 0;
  logic tmr_done = 1'b0;
  logic [5:0] sb_q[$];
  int   total = 0, bad = 0;
  bit   stim_done = 1'b0;

  task automatic step(input logic a, cs, ob, cb, obs, ol, cl, rn);
    int nph;
    arrive = a; car_stopped = cs; open_btn = ob; close_btn = cb;
    obstruct = obs; open_limit = ol; close_limit = cl; rst_n = rn;
    delay_done = tmr_done;
    nph = ph;
    if (!rn) begin
      nph = P_CLOSED;
      reopens = 0;
    end else if (ph != P_FAULT && ol && cl) begin
      nph = P_FAULT;
    end else begin
      case (ph)
        P_CLOSED:   if (a || (ob && cs)) nph = P_OPENING;
        P_OPENING:  if (ol) nph = P_HOLD_RST; else if (age == T - 1) nph = P_FAULT;
        P_HOLD_RST: nph = P_HOLD;
        P_HOLD:     if (ob || obs) nph = P_HOLD_RST; else if (cb || tmr_done) nph = P_CLOSING;
        P_CLOSING: begin
          if (cl) begin nph = P_CLOSED; reopens = 0; end
          else if (age == T - 1) nph = P_FAULT;
          else if (ob) nph = P_OPENING;
          else if (obs && reopens < MAXR) begin nph = P_OPENING; reopens++; end
        end
        default: nph = P_FAULT;
      endcase
    end
    // Timer registers the enable that is live during this cycle.
    if (ph == P_HOLD) begin tmr++; tmr_done = (tmr >= 4); end
    else begin tmr = 0; tmr_done = 1'b0; end
    age = (!rn || nph != ph) ? 0 : age + 1;
    ph  = nph;
    sb_q.push_back({ph == P_HOLD, ph == P_OPENING, ph == P_CLOSING, ph == P_CLOSED,
                    (reopens == MAXR) && (ph == P_HOLD_RST || ph == P_HOLD || ph == P_CLOSING),
                    ph == P_FAULT});
    @(negedge clk_50M);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 1, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic run_until(input int target, input int maxc);
    for (int i = 0; i < maxc && ph != target; i++) idle(1);
  endtask

  // Monitor: one expectation per clock edge.
  initial begin
    logic [5:0] exp_v, act_v;
    forever begin
      @(posedge clk_50M);
      #1;
      act_v = {delay_enable, motor_open, motor_close, door_closed, nudge, fault};
      if (sb_q.size() != 0) begin
        exp_v = sb_q.pop_front();
        total++;
        if (act_v !== exp_v) begin
          bad++;
          $display("FAIL outputs{en,mo,mc,dc,nudge,fault} @%0t: got %b want %b",
                   $time, act_v, exp_v);
        end
      end else if (!stim_done) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty @%0t: got no expectation, want one per edge", $time);
      end
    end
  end

  initial begin
    // Reset
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    // Full open / hold / close cycle
    step(1, 1, 0, 0, 0, 0, 0, 1);
    idle(2);
    step(0, 1, 0, 0, 0, 1, 0, 1);
    run_until(P_CLOSING, 20);
    idle(1);
    step(0, 1, 0, 0, 0, 0, 1, 1);
    idle(2);
    // open_btn during hold restarts the timer
    step(1, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1, 0, 1);
    run_until(P_HOLD, 5);
    idle(1);
    step(0, 1, 1, 0, 0, 0, 0, 1);
    run_until(P_CLOSING, 20);
    step(0, 1, 0, 0, 0, 0, 1, 1);
    idle(1);
    // Three obstruction reopens, then nudge ignores the fourth
    step(1, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1, 0, 1);
    run_until(P_CLOSING, 20);
    repeat (3) begin
      idle(1);
      step(0, 1, 0, 0, 1, 0, 0, 1);
      step(0, 1, 0, 0, 0, 1, 0, 1);
      run_until(P_CLOSING, 20);
    end
    step(0, 1, 0, 0, 1, 0, 0, 1);
    idle(2);
    step(0, 1, 0, 0, 0, 0, 1, 1);
    idle(2);
    // Opening timeout, arrive ignored in fault, reset recovers
    step(1, 1, 0, 0, 0, 0, 0, 1);
    idle(8);
    step(1, 1, 0, 0, 0, 0, 0, 1);
    idle(10);
    step(1, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    // open_btn gated by car_stopped
    step(0, 0, 1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1, 0, 1);
    run_until(P_CLOSING, 20);
    // Reset mid-close
    idle(2);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Closing timeout, then both limits at once
    step(1, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1, 0, 1);
    run_until(P_CLOSING, 20);
    idle(T + 1);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 1, 0, 0, 0, 1, 1, 1);
    idle(1);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic a, cs, ob, cb, obs, ol, cl, rn;
      a   = ($urandom % 20) == 0;
      cs  = ($urandom % 4) != 0;
      ob  = ($urandom % 25) == 0;
      cb  = ($urandom % 20) == 0;
      obs = ($urandom % 12) == 0;
      ol  = (ph == P_OPENING) ? (($urandom % 5) == 0) : (($urandom % 60) == 0);
      cl  = (ph == P_CLOSING) ? (($urandom % 5) == 0) : (($urandom % 60) == 0);
      rn  = ($urandom % 150) != 0;
      step(a, cs, ob, cb, obs, ol, cl, rn);
    end
    stim_done = 1'b1;
    @(posedge clk_50M);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
